// File: rtl/ctrl_pipe.sv
// Execute-stage control pipeline: condition evaluation, multi-cycle stall FSM,
// post-execute control shift chain and the architectural N/Z/C/V plus sticky flag register.
module ctrl_pipe #(
  parameter int              CW        = 16,
  parameter int              FW        = 5,
  parameter int              NPOST     = 2,
  parameter int              MULCYC    = 3,
  parameter logic [CW-1:0]   GATE_MASK = 16'h000F,
  parameter int              BR_BIT    = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CW-1:0]       ctrl_d,
  input  logic [3:0]          cond_d,
  input  logic                valid_d,
  input  logic [1:0]          flagw_d,
  input  logic                sat_d,
  input  logic                long_d,
  input  logic                flush_e,
  input  logic [FW-1:0]       alu_flags,
  input  logic                clr_sticky,
  output logic [CW-1:0]       ctrl_e,
  output logic                valid_e,
  output logic                cond_ex_e,
  output logic                branch_taken_e,
  output logic                stall_req,
  output logic [NPOST*CW-1:0] ctrl_post,
  output logic [NPOST-1:0]    valid_post,
  output logic [FW-1:0]       flags
);

  localparam int          CNTW     = $clog2(MULCYC) + 1;
  localparam logic        LONG_EN  = (MULCYC > 1);
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'((MULCYC > 1) ? (MULCYC - 2) : 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [3:0]      cond_e;
  logic [1:0]      flagw_e;
  logic            sat_e;
  logic            long_e;
  logic [FW-1:0]   flags_reg;
  logic [FW-1:0]   flags_next;
  logic            start_long;
  logic            complete;
  logic            commit;
  logic [CW-1:0]   post_ctrl  [NPOST];
  logic            post_valid [NPOST];

  function automatic logic cond_pass(input logic [3:0] c, input logic n, input logic z,
                                     input logic cf, input logic v);
    logic r;
    case (c)
      4'h0:    r = z;
      4'h1:    r = !z;
      4'h2:    r = cf;
      4'h3:    r = !cf;
      4'h4:    r = n;
      4'h5:    r = !n;
      4'h6:    r = v;
      4'h7:    r = !v;
      4'h8:    r = cf && !z;
      4'h9:    r = !cf || z;
      4'hA:    r = (n == v);
      4'hB:    r = (n != v);
      4'hC:    r = !z && (n == v);
      4'hD:    r = z || (n != v);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  assign cond_ex_e = cond_pass(cond_e, flags_reg[3], flags_reg[2], flags_reg[1], flags_reg[0]);

  // A long op that passes its condition occupies E for MULCYC cycles; E is frozen meanwhile.
  assign start_long = (state == IDLE) && valid_e && long_e && cond_ex_e && LONG_EN;
  assign complete   = ((state == IDLE) && !start_long) || ((state == BUSY) && (cnt == '0));
  assign stall_req  = start_long || ((state == BUSY) && (cnt != '0));
  assign commit     = complete && valid_e && cond_ex_e;

  assign branch_taken_e = commit && ctrl_e[BR_BIT];

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_e  <= '0;
      cond_e  <= '0;
      valid_e <= 1'b0;
      flagw_e <= '0;
      sat_e   <= 1'b0;
      long_e  <= 1'b0;
    end else if (!stall_req) begin
      if (flush_e) begin
        ctrl_e  <= '0;
        cond_e  <= '0;
        valid_e <= 1'b0;
        flagw_e <= '0;
        sat_e   <= 1'b0;
        long_e  <= 1'b0;
      end else begin
        ctrl_e  <= ctrl_d;
        cond_e  <= cond_d;
        valid_e <= valid_d;
        flagw_e <= flagw_d;
        sat_e   <= sat_d;
        long_e  <= long_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_long) begin
            state <= BUSY;
            cnt   <= CNT_LOAD;
          end
        end
        BUSY: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky bits: clear request and a same-cycle set resolve per bit in favour of the set.
  always_comb begin
    flags_next = flags_reg;
    if (commit) begin
      if (flagw_e[1]) flags_next[3:2] = alu_flags[3:2];
      if (flagw_e[0]) flags_next[1:0] = alu_flags[1:0];
    end
    flags_next[FW-1:4] = (clr_sticky ? '0 : flags_reg[FW-1:4])
                       | ((commit && sat_e) ? alu_flags[FW-1:4] : '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) flags_reg <= '0;
    else        flags_reg <= flags_next;
  end

  assign flags = flags_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      post_ctrl[0]  <= '0;
      post_valid[0] <= 1'b0;
    end else if (complete) begin
      post_ctrl[0]  <= ctrl_e & (~GATE_MASK | {CW{cond_ex_e}});
      post_valid[0] <= valid_e;
    end else begin
      post_ctrl[0]  <= '0;
      post_valid[0] <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < NPOST; gi++) begin : g_post
      always_ff @(posedge clk) begin
        if (!reset) begin
          post_ctrl[gi]  <= '0;
          post_valid[gi] <= 1'b0;
        end else begin
          post_ctrl[gi]  <= post_ctrl[gi-1];
          post_valid[gi] <= post_valid[gi-1];
        end
      end
    end
    for (gi = 0; gi < NPOST; gi++) begin : g_out
      assign ctrl_post[gi*CW +: CW] = post_ctrl[gi];
      assign valid_post[gi]         = post_valid[gi];
    end
  endgenerate

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: a scoreboard matches every control word leaving the W slot,
// while the stimulus process checks flags, stalls and E-stage status at fixed cycles.
module tb_ctrl_pipe;
  localparam int CW = 16, FW = 5, NPOST = 2, MULCYC = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic [CW-1:0]       ctrl_d;
  logic [3:0]          cond_d;
  logic                valid_d;
  logic [1:0]          flagw_d;
  logic                sat_d, long_d, flush_e, clr_sticky;
  logic [FW-1:0]       alu_flags;
  logic [CW-1:0]       ctrl_e;
  logic                valid_e, cond_ex_e, branch_taken_e, stall_req;
  logic [NPOST*CW-1:0] ctrl_post;
  logic [NPOST-1:0]    valid_post;
  logic [FW-1:0]       flags;

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;

  ctrl_pipe #(.CW(CW), .FW(FW), .NPOST(NPOST), .MULCYC(MULCYC)) dut (
    .clk(clk), .reset(reset), .ctrl_d(ctrl_d), .cond_d(cond_d), .valid_d(valid_d),
    .flagw_d(flagw_d), .sat_d(sat_d), .long_d(long_d), .flush_e(flush_e),
    .alu_flags(alu_flags), .clr_sticky(clr_sticky), .ctrl_e(ctrl_e), .valid_e(valid_e),
    .cond_ex_e(cond_ex_e), .branch_taken_e(branch_taken_e), .stall_req(stall_req),
    .ctrl_post(ctrl_post), .valid_post(valid_post), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor on the W slot.
  always @(negedge clk) begin
    if (reset === 1'b1 && valid_post[NPOST-1]) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL slot_w_unexpected: got %0h expected nothing", ctrl_post[(NPOST-1)*CW +: CW]);
      end else begin
        mon_exp = exp_q.pop_front();
        check("slot_w_ctrl", ctrl_post[(NPOST-1)*CW +: CW], mon_exp);
        $display("slot W ctrl %04h (expected %04h)", ctrl_post[(NPOST-1)*CW +: CW], mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; valid_d = 1'b1; ctrl_d = 16'hFFFF; cond_d = 4'h0; flagw_d = 2'b00;
    sat_d = 1'b0; long_d = 1'b0; flush_e = 1'b0; alu_flags = '0; clr_sticky = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid_e", valid_e, 0);
    check("rst_ctrl_post", ctrl_post, 0);
    check("rst_flags", flags, 0);
    check("rst_stall", stall_req, 0);

    // EQ fails with Z=0: low nibble gated off, still valid
    reset = 1'b1; ctrl_d = 16'h00FF; cond_d = 4'h0; valid_d = 1'b1;
    exp_q.push_back(16'h00F0);
    @(negedge clk);
    check("eq_valid_e", valid_e, 1);
    check("eq_cond_ex", cond_ex_e, 0);
    check("eq_branch", branch_taken_e, 0);
    valid_d = 1'b0;
    @(negedge clk);
    check("eq_slot0", ctrl_post[CW-1:0], 16'h00F0);
    check("eq_slot0_valid", valid_post[0], 1);
    check("eq_flags", flags, 0);
    repeat (2) @(negedge clk);

    // AL branch writing N,Z,C,V, then an EQ that sees the new Z=0
    ctrl_d = 16'h0011; cond_d = 4'hE; flagw_d = 2'b11; alu_flags = 5'b11010; valid_d = 1'b1;
    exp_q.push_back(16'h0011);
    @(negedge clk);
    check("al_branch", branch_taken_e, 1);
    ctrl_d = 16'h0021; cond_d = 4'h0; flagw_d = 2'b00;
    exp_q.push_back(16'h0020);
    @(negedge clk);
    check("al_flags", flags, 5'b01010);
    check("eq2_cond_ex", cond_ex_e, 0);
    check("eq2_branch", branch_taken_e, 0);
    valid_d = 1'b0; alu_flags = '0;
    repeat (3) @(negedge clk);

    // Long AL op followed by two ops held upstream during the stall
    ctrl_d = 16'h0100; cond_d = 4'hE; long_d = 1'b1; valid_d = 1'b1;
    exp_q.push_back(16'h0100); exp_q.push_back(16'h0200); exp_q.push_back(16'h0300);
    @(negedge clk);
    check("long_stall1", stall_req, 1);
    long_d = 1'b0; ctrl_d = 16'h0200;
    @(negedge clk);
    check("long_stall2", stall_req, 1);
    check("long_hold_e", ctrl_e, 16'h0100);
    check("long_bubble1", valid_post[0], 0);
    @(negedge clk);
    check("long_stall_end", stall_req, 0);
    check("long_bubble2", valid_post[0], 0);
    @(negedge clk);
    check("long_slot0_valid", valid_post[0], 1);
    check("long_slot0", ctrl_post[CW-1:0], 16'h0100);
    check("long_next_e", ctrl_e, 16'h0200);
    ctrl_d = 16'h0300;
    @(negedge clk);
    valid_d = 1'b0;
    repeat (3) @(negedge clk);

    // Flush in IDLE, then flush held during a stall
    ctrl_d = 16'h0400; valid_d = 1'b1; flush_e = 1'b1;
    @(negedge clk);
    check("flush_idle", valid_e, 0);
    flush_e = 1'b0; ctrl_d = 16'h0500; long_d = 1'b1;
    exp_q.push_back(16'h0500);
    @(negedge clk);
    check("flush_long_stall", stall_req, 1);
    flush_e = 1'b1; valid_d = 1'b0; long_d = 1'b0;
    @(negedge clk);
    check("flush_ignored_valid", valid_e, 1);
    check("flush_ignored_ctrl", ctrl_e, 16'h0500);
    @(negedge clk);
    flush_e = 1'b0;
    repeat (3) @(negedge clk);

    // Long op whose condition fails completes in one cycle
    ctrl_d = 16'h0600; cond_d = 4'h0; long_d = 1'b1; valid_d = 1'b1;
    exp_q.push_back(16'h0600);
    @(negedge clk);
    check("long_fail_nostall", stall_req, 0);
    valid_d = 1'b0; long_d = 1'b0; cond_d = 4'hE;
    repeat (3) @(negedge clk);

    // Sticky set, clear alone, clear with simultaneous set
    ctrl_d = 16'h0700; sat_d = 1'b1; alu_flags = 5'b10000; valid_d = 1'b1;
    exp_q.push_back(16'h0700);
    @(negedge clk);
    valid_d = 1'b0; sat_d = 1'b0;
    @(negedge clk);
    check("sticky_set", flags, 5'b11010);
    clr_sticky = 1'b1;
    @(negedge clk);
    check("sticky_clr", flags, 5'b01010);
    clr_sticky = 1'b0; ctrl_d = 16'h0800; sat_d = 1'b1; valid_d = 1'b1;
    exp_q.push_back(16'h0800);
    @(negedge clk);
    valid_d = 1'b0; sat_d = 1'b0; clr_sticky = 1'b1;
    @(negedge clk);
    check("sticky_set_wins", flags, 5'b11010);
    clr_sticky = 1'b0; alu_flags = '0;
    repeat (3) @(negedge clk);

    // Reset while BUSY aborts the long op
    ctrl_d = 16'h0900; long_d = 1'b1; flagw_d = 2'b11; valid_d = 1'b1;
    @(negedge clk);
    valid_d = 1'b0; long_d = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_flags", flags, 0);
    check("abort_stall", stall_req, 0);
    check("abort_valid_e", valid_e, 0);
    check("abort_valid_post", valid_post, 0);
    reset = 1'b1; flagw_d = 2'b00;
    repeat (4) @(negedge clk);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
